// File: rtl/summation_sched_pkg.sv
// Shared types and the modulo-M clamp/wrap arithmetic for summation_sched.
// Optional context clear is enabled by SUMMATION_SCHED_CLR_EN.
package summation_sched_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_M     = 1000;
  localparam int DEF_W     = 11;
  localparam int DEF_CNT_W = 10;

  typedef enum logic {IDLE, FULL} state_t;

  typedef struct packed {
    logic        cop;
    logic        con;
    logic [31:0] cnt;
  } wrap_t;

  // 32-bit int arithmetic gives the same results as a W+2-bit signed datapath
  function automatic wrap_t sum_wrap(input int cnt, input int addend, input int m);
    int    a;
    int    s;
    wrap_t r;
    a = addend;
    if (a > m - 1)
      a = m - 1;
    else if (a < -(m - 1))
      a = -(m - 1);
    s = cnt + a;
    r = '0;
    if (s >= m) begin
      r.cnt = 32'(s - m);
      r.cop = 1'b1;
    end else if (s < 0) begin
      r.cnt = 32'(s + m);
      r.con = 1'b1;
    end else begin
      r.cnt = 32'(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/summation_sched_if.sv
// Request/result bus of summation_sched; clear port exists only with SUMMATION_SCHED_CLR_EN.
interface summation_sched_if #(
  parameter int N     = 4,
  parameter int W     = 11,
  parameter int CNT_W = 10
);
  localparam int CH_W = $clog2(N);

  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_addend;
  logic [N-1:0]     req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [CNT_W-1:0] res_cnt;
  logic             res_cop;
  logic             res_con;
`ifdef SUMMATION_SCHED_CLR_EN
  logic             clr_valid;
  logic [CH_W-1:0]  clr_ch;
`endif

  modport master (
    output req_valid, req_addend, res_ready,
`ifdef SUMMATION_SCHED_CLR_EN
    output clr_valid, clr_ch,
`endif
    input  req_ready, res_valid, res_ch, res_cnt, res_cop, res_con
  );

  modport slave (
    input  req_valid, req_addend, res_ready,
`ifdef SUMMATION_SCHED_CLR_EN
    input  clr_valid, clr_ch,
`endif
    output req_ready, res_valid, res_ch, res_cnt, res_cop, res_con
  );

endinterface

// File: rtl/summation_sched_rr_arbiter.sv
// Stateless round-robin arbiter: lowest-index request at or after i_ptr wins.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [CH_W-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned j;
      j = (32'(i_ptr) + off) % N;
      if (!o_any && i_req[CH_W'(j)]) begin
        o_any            = 1'b1;
        o_gnt[CH_W'(j)]  = 1'b1;
        o_idx            = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/summation_sched.sv
// N-channel shared modulo-M accumulator with round-robin grant and registered result.
// SUMMATION_SCHED_CLR_EN adds a per-channel context clear that wins over a same-cycle grant.
module summation_sched
  import summation_sched_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic          clk,
  input logic          arst,
  summation_sched_if.slave bus
);
  localparam int CH_W = $clog2(N);

  state_t           r_state, w_state_nxt;
  logic [CH_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_cnt [N];
  logic [CH_W-1:0]  r_res_ch;
  logic [CNT_W-1:0] r_res_cnt;
  logic             r_res_cop, r_res_con;

  logic [N-1:0]     w_gnt;
  logic [CH_W-1:0]  w_idx;
  logic             w_any, w_can_grant, w_fire, w_clr;
  logic [W-1:0]     w_addend;
  logic [CNT_W-1:0] w_cur;
  wrap_t            w_wrap;

  rr_arbiter #(.N(N)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_can_grant = !arst && ((r_state == IDLE) || bus.res_ready);
    w_fire      = w_can_grant && w_any;
    w_addend    = bus.req_addend[w_idx*W +: W];
`ifdef SUMMATION_SCHED_CLR_EN
    w_clr       = bus.clr_valid;
`else
    w_clr       = 1'b0;
`endif
    w_cur       = r_cnt[w_idx];
`ifdef SUMMATION_SCHED_CLR_EN
    if (w_clr && (bus.clr_ch == w_idx))
      w_cur = '0;
`endif
    w_wrap      = sum_wrap(int'(w_cur), int'($signed(w_addend)), M);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_fire) w_state_nxt = FULL;
      FULL: if (bus.res_ready && !w_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_res_ch  <= '0;
      r_res_cnt <= '0;
      r_res_cop <= 1'b0;
      r_res_con <= 1'b0;
      for (int unsigned i = 0; i < N; i++)
        r_cnt[CH_W'(i)] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_ptr     <= (w_idx == CH_W'(N - 1)) ? '0 : w_idx + CH_W'(1);
        r_res_ch  <= w_idx;
        r_res_cnt <= CNT_W'(w_wrap.cnt);
        r_res_cop <= w_wrap.cop;
        r_res_con <= w_wrap.con;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (w_fire && (w_idx == CH_W'(i)))
          r_cnt[CH_W'(i)] <= CNT_W'(w_wrap.cnt);
`ifdef SUMMATION_SCHED_CLR_EN
        else if (w_clr && (bus.clr_ch == CH_W'(i)))
          r_cnt[CH_W'(i)] <= '0;
`endif
      end
    end
  end

  assign bus.req_ready = w_fire ? w_gnt : '0;
  assign bus.res_valid = (r_state == FULL);
  assign bus.res_ch    = r_res_ch;
  assign bus.res_cnt   = r_res_cnt;
  assign bus.res_cop   = r_res_cop;
  assign bus.res_con   = r_res_con;

endmodule

// File: tb/tb_summation_sched.sv
// Scoreboard bench for summation_sched; exercises the clear path when SUMMATION_SCHED_CLR_EN is defined.
module tb_summation_sched;
  localparam int N     = 4;
  localparam int M     = 1000;
  localparam int W     = 12;
  localparam int CNT_W = 10;

  typedef struct {
    int ch;
    int cnt;
    int cop;
    int con;
  } exp_t;

  logic clk;
  logic arst;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  summation_sched_if #(.N(N), .W(W), .CNT_W(CNT_W)) bus ();

  summation_sched #(.N(N), .M(M), .W(W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input int ch, input int val);
    logic [W-1:0] v;
    v = W'(val);
    bus.req_addend[ch*W +: W] = v;
  endtask

  task automatic push(input int ch, input int cnt, input int cop, input int con);
    exp_t e;
    e.ch = ch; e.cnt = cnt; e.cop = cop; e.con = con;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    arst = 1'b0;
  endtask

  // Monitor: a result transfers on the next rising edge when valid & ready.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got ch=%0d cnt=%0d cop=%0d con=%0d expected none",
                   bus.res_ch, bus.res_cnt, bus.res_cop, bus.res_con);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (int'(bus.res_ch) != e.ch || int'(bus.res_cnt) != e.cnt ||
              int'(bus.res_cop) != e.cop || int'(bus.res_con) != e.con) begin
            n_fail++;
            $display("FAIL result: got ch=%0d cnt=%0d cop=%0d con=%0d expected ch=%0d cnt=%0d cop=%0d con=%0d",
                     bus.res_ch, bus.res_cnt, bus.res_cop, bus.res_con, e.ch, e.cnt, e.cop, e.con);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst = 1'b1;
    bus.req_valid  = '0;
    bus.req_addend = '0;
    bus.res_ready  = 1'b0;
`ifdef SUMMATION_SCHED_CLR_EN
    bus.clr_valid  = 1'b0;
    bus.clr_ch     = '0;
`endif
    do_reset();
    chk("reset_res_valid", int'(bus.res_valid), 0);
    chk("reset_req_ready", int'(bus.req_ready), 0);
    chk("reset_res_ch",    int'(bus.res_ch), 0);
    chk("reset_res_cnt",   int'(bus.res_cnt), 0);
    chk("reset_res_cop",   int'(bus.res_cop), 0);
    chk("reset_res_con",   int'(bus.res_con), 0);

    // Test 1: ch0 +5 three times
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    set_add(0, 5);
    push(0, 5, 0, 0); push(0, 10, 0, 0); push(0, 15, 0, 0);
    tick(); tick(); tick();
    bus.req_valid = '0;
    tick(); tick();

    // Test 2: wrap up and down on ch1
    bus.req_valid = 4'b0010;
    set_add(1, 999); push(1, 999, 0, 0); tick();
    set_add(1, -4);  push(1, 995, 0, 0); tick();
    set_add(1, 9);   push(1, 4, 1, 0);   tick();
    set_add(1, -9);  push(1, 995, 0, 1); tick();
    bus.req_valid = '0;
    tick(); tick();

    // Test 3: all channels requesting, round-robin order
    do_reset();
    for (int c = 0; c < N; c++) set_add(c, c + 1);
    bus.req_valid = 4'b1111;
    push(0, 1, 0, 0); push(1, 2, 0, 0); push(2, 3, 0, 0); push(3, 4, 0, 0);
    push(0, 2, 0, 0); push(1, 4, 0, 0); push(2, 6, 0, 0); push(3, 8, 0, 0);
    for (int k = 0; k < 8; k++) tick();

    // Test 4: stall with requests pending
    push(0, 3, 0, 0);
    tick();
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_req_ready", int'(bus.req_ready), 0);
      chk("stall_res_valid", int'(bus.res_valid), 1);
      chk("stall_res_ch",    int'(bus.res_ch), 0);
      chk("stall_res_cnt",   int'(bus.res_cnt), 3);
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("release_req_ready", int'(bus.req_ready), 2);
    push(1, 6, 0, 0);
    tick();
    bus.req_valid = '0;
    tick(); tick();

    // Test 5: clamping and exact boundaries on ch3
    do_reset();
    bus.req_valid = 4'b1000;
    set_add(3, 1500);  push(3, 999, 0, 0); tick();
    set_add(3, -1500); push(3, 0, 0, 0);   tick();
    set_add(3, -1500); push(3, 1, 0, 1);   tick();
    set_add(3, 0);     push(3, 1, 0, 0);   tick();
    set_add(3, 999);   push(3, 0, 1, 0);   tick();
    bus.req_valid = '0;
    tick(); tick();

    // Test 6: reset mid-burst drops the held result and clears contexts
    do_reset();
    for (int c = 0; c < N; c++) set_add(c, 7);
    bus.req_valid = 4'b1111;
    push(0, 7, 0, 0);
    tick(); tick();
    arst = 1'b1;
    bus.res_ready = 1'b0;
    tick();
    chk("midrst_res_valid", int'(bus.res_valid), 0);
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    chk("midrst_res_cnt",   int'(bus.res_cnt), 0);
    arst = 1'b0;
    bus.res_ready = 1'b1;
    bus.req_valid = '0;
    tick();
    for (int c = 0; c < N; c++) begin
      bus.req_valid = '0;
      bus.req_valid[c] = 1'b1;
      set_add(c, 0);
      push(c, 0, 0, 0);
      tick();
    end
    bus.req_valid = '0;
    tick(); tick();

`ifdef SUMMATION_SCHED_CLR_EN
    bus.req_valid = 4'b0100;
    set_add(2, 5); push(2, 5, 0, 0); tick();
    bus.clr_valid = 1'b1;
    bus.clr_ch    = 2'd2;
    set_add(2, 3); push(2, 3, 0, 0); tick();
    bus.clr_valid = 1'b0;
    bus.req_valid = '0;
    tick(); tick();
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
